// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: 2-entry skid-buffered pipeline register with flush, stall and bubble squashing
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WRegEn_in,
  input  logic              WMemEn_in,
  input  logic [DATA_W-1:0] R1out_in,
  input  logic [DATA_W-1:0] R2out_in,
  input  logic [REG_AW-1:0] WReg1_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WRegEn_out,
  output logic              WMemEn_out,
  output logic [DATA_W-1:0] R1out_out,
  output logic [DATA_W-1:0] R2out_out,
  output logic [REG_AW-1:0] WReg1_out,
  output logic [1:0]        occupancy
);
  localparam int W = 2 + 2 * DATA_W + REG_AW;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [W-1:0] main_q, skid_q, in_e;
  logic accept, deliver, load_main, load_skid;
  assign in_e = {WRegEn_in, WMemEn_in, R1out_in, R2out_in, WReg1_in};
  assign accept = in_valid & in_ready & en & ~flush;
  assign deliver = out_valid & out_ready & en & ~flush;
  // FULL never accepts, so main reloads from skid there and from the inputs otherwise
  assign load_main = (accept & (state == EMPTY | deliver)) | (deliver & state == FULL);
  assign load_skid = accept & state == ONE & ~deliver;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      if (load_main) main_q <= state == FULL ? skid_q : in_e;
      if (load_skid) skid_q <= in_e;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = accept ? ONE : EMPTY;
      ONE:     state_nx = accept & ~deliver ? FULL : (~accept & deliver ? EMPTY : ONE);
      default: state_nx = deliver ? ONE : FULL;
    endcase
    if (flush) state_nx = EMPTY;
  end
  always_comb begin
    in_ready  = ~reset & (state != FULL);
    out_valid = state != EMPTY;
    occupancy = state;
    {WRegEn_out, WMemEn_out, R1out_out, R2out_out, WReg1_out} = main_q;
    WRegEn_out = main_q[W-1] & out_valid;
    WMemEn_out = main_q[W-2] & out_valid;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of the R1out/R2out data fields.
REQ-002 SHALL have parameter REG_AW, default 3: width of the WReg1 destination-register field.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port en, input, 1: global stage enable; 0 freezes all state.
REQ-006 SHALL have port flush, input, 1: discards all buffered entries.
REQ-007 SHALL have port in_valid, input, 1: upstream entry valid.
REQ-008 SHALL have port in_ready, output, 1: stage can accept an entry.
REQ-009 SHALL have ports WRegEn_in and WMemEn_in, input, 1 each: register-write and memory-write controls.
REQ-010 SHALL have ports R1out_in and R2out_in, input, DATA_W each: operand/result data.
REQ-011 SHALL have port WReg1_in, input, REG_AW: destination register.
REQ-012 SHALL have port out_valid, output, 1: downstream entry valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the entry.
REQ-014 SHALL have ports WRegEn_out, WMemEn_out, R1out_out, R2out_out and WReg1_out, output, with widths matching the corresponding inputs.
REQ-015 SHALL have port occupancy, output, 2: number of buffered entries (0..2).

Function
REQ-016 SHALL implement a 2-entry skid buffer: a main register that drives the outputs, plus a skid register.
REQ-017 SHALL use states EMPTY (0 entries), ONE (main valid) and FULL (main and skid valid); occupancy SHALL be 0, 1 or 2 accordingly.
REQ-018 SHALL define accept = in_valid & in_ready & en & ~flush.
REQ-019 SHALL define deliver = out_valid & out_ready & en & ~flush.
REQ-020 SHALL drive in_ready = ~reset & (state != FULL); it SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid = (state != EMPTY).
REQ-022 SHALL, in EMPTY on accept, load main from the inputs and go to ONE.
REQ-023 SHALL, in ONE:
- on accept without deliver, load skid from the inputs and go to FULL;
- on accept with deliver, load main from the inputs and stay in ONE;
- on deliver without accept, go to EMPTY.
REQ-024 SHALL, in FULL on deliver, copy skid into main and go to ONE; no accept is possible in FULL.
REQ-025 SHALL have a latency of 1 cycle: an entry accepted at edge N appears on the outputs after edge N when the stage was EMPTY, or when it was ONE and delivered in the same cycle.
REQ-026 SHALL preserve strict FIFO order, and SHALL never drop or duplicate an entry under any in_valid/out_ready pattern.
REQ-027 SHALL, when flush=1 at an edge (with en=1 or en=0), go to EMPTY; flush SHALL override a simultaneous accept or deliver, and the data registers SHALL keep their values.
REQ-028 SHALL, when en=0 and flush=0, hold state, data and occupancy unchanged; in_ready and out_valid SHALL still reflect the held state.
REQ-029 SHALL force WRegEn_out=0 and WMemEn_out=0 whenever out_valid=0 (bubble squashing); R1out_out, R2out_out and WReg1_out SHALL hold the main register contents.
REQ-030 SHALL give all data fields identical treatment, with no width conversion.

Reset
REQ-031 SHALL, on reset=1 at an edge, set state EMPTY, main and skid data to 0, out_valid=0, occupancy=0 and all *_out=0; reset SHALL override flush, en and all handshakes.
REQ-032 SHALL ignore inputs in the reset cycle; in_ready=0 while reset=1 and SHALL be 1 on the first cycle after reset deasserts.
REQ-033 SHALL discard buffered entries when reset is asserted mid-operation, including in FULL; no entry SHALL emerge afterwards.

Verification
REQ-034 SHALL cover streaming: out_ready=1, five back-to-back entries with R1out_in=1..5 -> out_valid=1 with R1out_out=1..5 on consecutive cycles, occupancy=1 throughout, in_ready=1 throughout.
REQ-035 SHALL cover backpressure: out_ready=0, push A=0xAA then B=0xBB -> occupancy=2, in_ready=0; then out_ready=1 -> A out, then B out, then out_valid=0.
REQ-036 SHALL cover flush in FULL with a simultaneous in_valid=1 -> next cycle occupancy=0, out_valid=0, WRegEn_out=0, WMemEn_out=0, and the offered entry not captured.
REQ-037 SHALL cover en=0 for 3 cycles in ONE with out_ready=1 and in_valid=1 -> outputs and occupancy unchanged; after en=1 the held entry is delivered once.
REQ-038 SHALL cover reset in FULL with WRegEn/WMemEn=1 entries -> next cycle all outputs 0, occupancy=0, in_ready=1 after reset deasserts.
REQ-039 SHALL cover a randomised in_valid/out_ready stream of 1000 entries with DATA_W=32 and REG_AW=5 -> scoreboard shows in-order, loss-free, duplicate-free delivery.
